// File: rtl/poliriscv_dmem_arb.sv
// Two-master arbiter for the poliriscv data memory port: the core (m0) has fixed
// priority, the debug/loader port (m1) is guaranteed a grant after MAXWAIT denied cycles.
module poliriscv_dmem_arb #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MAXWAIT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] WAIT_MAX = 4'(MAXWAIT);

    logic [3:0] wait_cnt;
    logic       rpend;
    logic       rsel;
    logic       m1_wins;
    logic       read_granted;

    // m1 overrides the core once it has been starved for MAXWAIT cycles;
    // grants are gated by reset so nothing reaches memory while rst is low.
    always_comb begin
        m1_wins   = m1_req && (!m0_req || wait_cnt == WAIT_MAX);
        m1_gnt    = rst && m1_wins;
        m0_gnt    = rst && m0_req && !m1_wins;
        mem_en    = m0_gnt | m1_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (m1_gnt) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end else if (m0_gnt) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end
    end

    assign read_granted = mem_en && !mem_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
            rpend    <= 1'b0;
            rsel     <= 1'b0;
        end else begin
            if (!m1_req || m1_gnt) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            rpend <= read_granted;
            if (read_granted) begin
                rsel <= m1_gnt;
            end
        end
    end

    // Read data is steered only to the master whose read was granted last cycle.
    assign m0_rvalid = rpend && !rsel;
    assign m1_rvalid = rpend && rsel;
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_poliriscv_dmem_arb.sv
// Bench for poliriscv_dmem_arb: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level model with a shadow memory.
module tb_poliriscv_dmem_arb;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int MAXWAIT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_gnt, m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_gnt, m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    logic [31:0] mem    [64];
    logic [31:0] shadow [64];

    int checks = 0;
    int errors = 0;

    int          denied  = 0;
    int          rv_who  = -1;
    logic [31:0] rv_data = '0;
    logic        eg0, eg1;

    always #5 clk = ~clk;

    poliriscv_dmem_arb #(.AW(AW), .DW(DW), .MAXWAIT(MAXWAIT)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Synchronous memory: read data valid the cycle after the access, garbage otherwise.
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[7:2]];
        else mem_rdata <= $urandom;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs from the arbitration rules: m1 goes first if the core is idle
    // or m1 has already been refused MAXWAIT times in a row.
    task automatic checkOutput();
        logic        m1_turn;
        logic        exp_we;
        logic [31:0] exp_addr, exp_wdata;
        m1_turn = m1_req && (!m0_req || denied >= MAXWAIT);
        eg1 = rst && m1_turn;
        eg0 = rst && m0_req && !m1_turn;
        exp_we    = eg1 ? m1_we    : (eg0 ? m0_we    : 1'b0);
        exp_addr  = eg1 ? m1_addr  : (eg0 ? m0_addr  : 32'h0);
        exp_wdata = eg1 ? m1_wdata : (eg0 ? m0_wdata : 32'h0);
        check("m0_gnt", 32'(m0_gnt), 32'(eg0));
        check("m1_gnt", 32'(m1_gnt), 32'(eg1));
        check("mem_en", 32'(mem_en), 32'(eg0 | eg1));
        check("mem_we", 32'(mem_we), 32'(exp_we));
        check("mem_addr", mem_addr, exp_addr);
        check("mem_wdata", mem_wdata, exp_wdata);
        check("m0_rvalid", 32'(m0_rvalid), 32'(rv_who == 0));
        check("m1_rvalid", 32'(m1_rvalid), 32'(rv_who == 1));
        check("m0_rdata", m0_rdata, (rv_who == 0) ? rv_data : 32'h0);
        check("m1_rdata", m1_rdata, (rv_who == 1) ? rv_data : 32'h0);
    endtask

    task automatic modelUpdate();
        if (!rst) begin
            denied = 0;
            rv_who = -1;
        end else begin
            rv_who = -1;
            if (eg0 && !m0_we) begin
                rv_who  = 0;
                rv_data = shadow[m0_addr[7:2]];
            end
            if (eg1 && !m1_we) begin
                rv_who  = 1;
                rv_data = shadow[m1_addr[7:2]];
            end
            if (eg0 && m0_we) shadow[m0_addr[7:2]] = m0_wdata;
            if (eg1 && m1_we) shadow[m1_addr[7:2]] = m1_wdata;
            if (m1_req && !eg1) denied = (denied < MAXWAIT) ? denied + 1 : MAXWAIT;
            else denied = 0;
        end
    endtask

    // One cycle: drive at the falling edge, check just after, optionally drop
    // reset 2 ns before the next rising edge.
    task automatic applyStimulus(input logic r,
                                 input logic q0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                                 input logic q1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                                 input bit pulse);
        @(negedge clk);
        rst = r;
        m0_req = q0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = q1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        #1;
        checkOutput();
        if (pulse) begin
            #2;
            rst = 1'b0;
            #1;
            check("pulse_m0_gnt", 32'(m0_gnt), 32'h0);
            check("pulse_mem_en", 32'(mem_en), 32'h0);
        end
        modelUpdate();
    endtask

    task automatic idle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        bit          p0v = 1'b0, p1v = 1'b0, pulse;
        logic        p0w = 1'b0, p1w = 1'b0;
        logic [31:0] p0a = '0, p0d = '0, p1a = '0, p1d = '0;

        for (int i = 0; i < 64; i++) begin
            mem[i]    = $urandom;
            shadow[i] = mem[i];
        end
        mem[4]    = 32'hDEADBEEF;
        shadow[4] = 32'hDEADBEEF;

        #1 rst = 1'b0;

        // Reset with both masters requesting, then release.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        check("rst_m0_gnt", 32'(m0_gnt), 32'h0);
        check("rst_m1_gnt", 32'(m1_gnt), 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_m0_rvalid", 32'(m0_rvalid), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        check("rel_m0_gnt", 32'(m0_gnt), 32'h1);
        check("rel_mem_addr", mem_addr, 32'h10);
        idle();
        check("rd_m0_rvalid", 32'(m0_rvalid), 32'h1);
        check("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
        check("rd_m1_rvalid", 32'(m1_rvalid), 32'h0);
        idle();

        // Continuous contention: m0,m0,m0,m1 repeating.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
            check("cont_wait_cnt", 32'(dut.wait_cnt), 32'(i % 4));
            check("cont_m1_gnt", 32'(m1_gnt), 32'(i % 4 == 3));
        end
        idle();

        // m1 write with core idle, then core reads it back.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h55, 1'b0);
        check("wr_m1_gnt", 32'(m1_gnt), 32'h1);
        check("wr_mem_we", 32'(mem_we), 32'h1);
        check("wr_mem_wdata", mem_wdata, 32'h55);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("wr_m1_rvalid", 32'(m1_rvalid), 32'h0);
        check("wr_m0_rvalid", 32'(m0_rvalid), 32'h0);
        idle();
        check("wrrd_m0_rvalid", 32'(m0_rvalid), 32'h1);
        check("wrrd_m0_rdata", m0_rdata, 32'h55);

        // Back-to-back reads from different masters.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        check("b2b_m0_rvalid", 32'(m0_rvalid), 32'h1);
        check("b2b_m1_rvalid_early", 32'(m1_rvalid), 32'h0);
        check("b2b_m1_rdata_early", m1_rdata, 32'h0);
        idle();
        check("b2b_m1_rvalid", 32'(m1_rvalid), 32'h1);
        check("b2b_m0_rvalid_late", 32'(m0_rvalid), 32'h0);
        check("b2b_m0_rdata_late", m0_rdata, 32'h0);

        // Reset pulse just before the edge that would return a granted read.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'hC, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'hC, 32'h0, 1'b1);
        idle();
        check("rstmid_m0_rvalid", 32'(m0_rvalid), 32'h0);
        check("rstmid_wait_cnt", 32'(dut.wait_cnt), 32'h0);

        // m1 gives up while waiting.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h4, 32'h0, 1'b0);
        check("abandon_wait_cnt_hold", 32'(dut.wait_cnt), 32'h2);
        check("abandon_m1_gnt", 32'(m1_gnt), 32'h0);
        idle();
        check("abandon_wait_cnt_clr", 32'(dut.wait_cnt), 32'h0);

        // Randomized traffic obeying the hold-until-grant rule.
        for (int c = 0; c < 3000; c++) begin
            if (!p0v && $urandom_range(0, 2) == 0) begin
                p0v = 1'b1;
                p0w = 1'($urandom_range(0, 1));
                p0a = 32'($urandom_range(0, 15)) << 2;
                p0d = $urandom;
            end
            if (!p1v && $urandom_range(0, 1) == 0) begin
                p1v = 1'b1;
                p1w = 1'($urandom_range(0, 1));
                p1a = 32'($urandom_range(0, 15)) << 2;
                p1d = $urandom;
            end
            pulse = ($urandom_range(0, 199) == 0);
            applyStimulus(1'b1, p0v, p0w, p0a, p0d, p1v, p1w, p1a, p1d, pulse);
            if (eg0) p0v = 1'b0;
            if (eg1) p1v = 1'b0;
            else if (p1v && $urandom_range(0, 15) == 0) p1v = 1'b0;
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/poliriscv_dmem_arb.md
Name: poliriscv_dmem_arb

Overview:
- Arbiter sharing the single data memory port of the single-cycle poliriscv core between two requesters.
- Master 0 is the core load/store path. Master 1 is the debug/loader port used by benches and boot loading.
- Master 0 has fixed priority. Master 1 has a bounded-wait guarantee.
- A denied core request stalls the core: PC is held while m0_req is high and m0_gnt is low.

Parameters:
AW, 32, address width
DW, 32, data width
MAXWAIT, 3, consecutive denied cycles after which a waiting m1 request overrides m0 (legal range 1..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
m0_req  input  1  core access request
m0_we  input  1  1 = write, 0 = read
m0_addr  input  AW  byte address
m0_wdata  input  DW  write data
m0_gnt  output  1  access accepted this cycle
m0_rvalid  output  1  read data valid (one cycle after granted read)
m0_rdata  output  DW  read data
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as m0_*, for master 1
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data, valid the cycle after mem_en && !mem_we

Behaviour:
- Reset (rst=0, asynchronous):
  - wait_cnt=0, rsel=0, rpend=0, m0_rvalid=0, m1_rvalid=0.
  - While rst=0: m0_gnt=m1_gnt=mem_en=0.
- Request rule:
  - A master holds req, we, addr and wdata stable from assertion until the cycle its gnt is high.
  - A transfer completes in the cycle req && gnt.
- Grant decision (combinational from current req and registered wait_cnt):
  - m1 wins when m1_req && (!m0_req || wait_cnt==MAXWAIT).
  - Otherwise m0 wins when m0_req.
  - At most one gnt high per cycle.
- Memory drive:
  - mem_en = m0_gnt|m1_gnt.
  - mem_we/addr/wdata are muxed from the granted master.
  - All are 0 when no grant.
- wait_cnt (4-bit register), at each edge:
  - 0 if !m1_req or m1_gnt.
  - Otherwise wait_cnt+1, saturating at MAXWAIT.
- Read response:
  - On an edge where a read is granted: rpend<=1, rsel<=granted master index. Otherwise rpend<=0.
  - mX_rvalid = rpend && (rsel==X), registered.
  - mX_rdata = mem_rdata when mX_rvalid, else 0.
- Writes produce no rvalid.
- Back-to-back reads are allowed every cycle. The response for cycle N's grant appears in cycle N+1, concurrent with a new grant.
- Simultaneous events:
  - An m1 grant in the cycle m1 just crossed the threshold takes effect that cycle. wait_cnt then returns to 0 next edge.
  - When m1 deasserts req while waiting, wait_cnt clears next edge and no grant is issued.
- Reset mid-operation: a read granted in cycle N with rst falling before the N+1 edge produces no rvalid. Outstanding state is discarded.
- Both masters idle: all outputs 0 except passive rdata=0.

Test Plan:
- Reset: rst=0 with m0_req=m1_req=1 -> both gnt=0, mem_en=0, both rvalid=0; after rst=1, first edge -> m0_gnt=1.
- m0-only read, addr 0x10, memory holding 0xDEADBEEF -> m0_gnt=1 cycle 0, mem_en=1, mem_addr=0x10; cycle 1 m0_rvalid=1, m0_rdata=0xDEADBEEF, m1_rvalid=0.
- Both requesting continuously, MAXWAIT=3 -> grant pattern m0,m0,m0,m1 repeating; wait_cnt sequence 0,1,2,3,0.
- m1 write 0x00000055 to 0x40 with m0 idle -> m1_gnt=1 same cycle, mem_we=1, mem_wdata=0x55; no rvalid; a following m0 read of 0x40 returns 0x55.
- Back-to-back reads m0@0x0 then m1@0x4 -> cycle 1 m0_rvalid=1; cycle 2 m1_rvalid=1; rdata routed correctly, never to both.
- Reset mid-read: m0 read granted, rst=0 pulsed 2 ns before next edge -> m0_rvalid stays 0, wait_cnt=0 after release.
